// File: rtl/sc_stream_decoder.sv
`default_nettype none
// ============================================================================
// Module   : sc_stream_decoder
// Brief    : Stochastic-to-binary back end. Counts ones on LANES parallel
//            stochastic bit lanes over a 2^N-cycle window and returns the
//            unipolar count or the signed bipolar value under valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module sc_stream_decoder #(
    parameter  int N     = 12,
    parameter  int LANES = 4,
    localparam int OUT_W = N + $clog2(LANES) + 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             bipolar,
    input  logic [LANES-1:0] bit_in,
    output logic             busy,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    input  logic             out_ready
);

    // Full-scale ones count (every lane high for the whole window).
    localparam logic [OUT_W-1:0] c_FULL     = OUT_W'(LANES * (2 ** N));
    localparam logic [N-1:0]     c_CYC_LAST = {N{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [N-1:0]     r_cyc;
    logic [OUT_W-1:0] r_acc;
    logic             r_bipolar;
    logic             r_busy;
    logic             r_out_valid;
    logic [OUT_W-1:0] r_out_data;

    logic             w_accept;
    logic [OUT_W-1:0] w_pop;
    logic [OUT_W-1:0] w_sum;
    logic [OUT_W-1:0] w_result;

    // Population count of the current lane bits.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < LANES; i++) begin
            w_pop = w_pop + OUT_W'(bit_in[i]);
        end
    end

    // Running total including this cycle's sample, and the formatted result.
    // Bipolar arithmetic is done modulo 2^OUT_W, which yields two's complement.
    always_comb begin
        w_sum    = r_acc + w_pop;
        w_result = r_bipolar ? ((w_sum << 1) - c_FULL) : w_sum;
    end

    // A window opens from IDLE, or from HOLD in the same cycle the result is taken.
    assign w_accept = start && ((r_state == S_IDLE) ||
                                ((r_state == S_HOLD) && out_ready));

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_COUNT;
            S_COUNT: if (r_cyc == c_CYC_LAST) w_state_next = S_HOLD;
            S_HOLD:  if (out_ready) w_state_next = start ? S_COUNT : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register plus registered busy/valid flags decoded from next state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_busy      <= (w_state_next == S_COUNT);
            r_out_valid <= (w_state_next == S_HOLD);
        end
    end

    // Window datapath: the accept cycle is sample 0, so the accumulator is
    // loaded rather than cleared, and the last sample folds straight into the result.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cyc      <= '0;
            r_acc      <= '0;
            r_bipolar  <= 1'b0;
            r_out_data <= '0;
        end else if (w_accept) begin
            r_cyc     <= N'(1);
            r_acc     <= w_pop;
            r_bipolar <= bipolar;
        end else if (r_state == S_COUNT) begin
            r_cyc <= r_cyc + N'(1);
            r_acc <= w_sum;
            if (r_cyc == c_CYC_LAST) begin
                r_out_data <= w_result;
            end
        end
    end

    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_sc_stream_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_sc_stream_decoder
// Brief    : Scoreboard bench for sc_stream_decoder at N=4, LANES=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sc_stream_decoder;

    localparam int N     = 4;
    localparam int LANES = 4;
    localparam int OUT_W = 8;
    localparam int WIN   = 16;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic             bipolar = 1'b0;
    logic [LANES-1:0] bit_in = '0;
    logic             busy;
    logic             out_valid;
    logic [OUT_W-1:0] out_data;
    logic             out_ready = 1'b1;

    int checks   = 0;
    int failures = 0;
    bit rand_ready = 1'b0;

    logic [OUT_W-1:0] exp_q[$];
    bit               pending = 1'b0;
    logic [OUT_W-1:0] held;

    sc_stream_decoder #(.N(N), .LANES(LANES)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .bipolar   (bipolar),
        .bit_in    (bit_in),
        .busy      (busy),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 2) != 0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || out_valid) && n < 300) begin
            tick();
            n++;
        end
        if (busy || out_valid) begin
            checks++;
            failures++;
            $display("FAIL wait_idle: timeout busy=%0b valid=%0b", busy, out_valid);
        end
    endtask

    // One window: pattern chosen up front so the expected result is queued at issue.
    task automatic run_window(input logic bip, input bit rnd, input logic [3:0] val,
                              input bit no_wait, input bit poke);
        logic [3:0]       pat [WIN];
        int               ones;
        logic [OUT_W-1:0] e;
        if (!no_wait) wait_idle();
        ones = 0;
        for (int i = 0; i < WIN; i++) begin
            pat[i] = rnd ? 4'($urandom) : val;
            ones += $countones(pat[i]);
        end
        e = bip ? OUT_W'(2 * ones - 64) : OUT_W'(ones);
        exp_q.push_back(e);
        for (int i = 0; i < WIN; i++) begin
            start   = (i == 0) || (poke && i == 5);
            bipolar = (i == 0) ? bip : ~bip;
            bit_in  = pat[i];
            tick();
            if (i == 0) chk("busy_after_start", busy, 1);
        end
        start  = 1'b0;
        bit_in = 'x;
        chk("valid_latency", out_valid, 1);
        chk("busy_done", busy, 0);
    endtask

    // Monitor: pop on each new result, then check it stays put until taken.
    always @(negedge clock) begin
        if (!reset_n) begin
            pending = 1'b0;
        end else if (out_valid) begin
            if (!pending) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result: got %0h with empty queue", out_data);
                end else begin
                    logic [OUT_W-1:0] e;
                    e = exp_q.pop_front();
                    checks++;
                    if (out_data !== e) begin
                        failures++;
                        $display("FAIL result: got %0h expected %0h at %0t", out_data, e, $time);
                    end
                end
                held    = out_data;
                pending = 1'b1;
            end else begin
                checks++;
                if (out_data !== held) begin
                    failures++;
                    $display("FAIL hold_stable: got %0h expected %0h", out_data, held);
                end
            end
            if (out_ready) pending = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit_in = 'x;
        #12;
        chk("reset_busy", busy, 0);
        chk("reset_valid", out_valid, 0);
        chk("reset_data", out_data, 0);
        reset_n = 1'b1;
        tick();

        // 1. All ones, unipolar -> 64
        run_window(1'b0, 1'b0, 4'hF, 1'b0, 1'b0);

        // 2. Bipolar all zeros -> -64; 0101 bipolar -> 0; 0101 unipolar -> 32
        run_window(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        run_window(1'b1, 1'b0, 4'b0101, 1'b0, 1'b0);
        run_window(1'b0, 1'b0, 4'b0101, 1'b0, 1'b0);

        // 3. Stall for 10 cycles; start pulses in COUNT and HOLD must be ignored
        wait_idle();
        out_ready = 1'b0;
        run_window(1'b0, 1'b0, 4'hF, 1'b0, 1'b1);
        for (int k = 0; k < 10; k++) begin
            start = (k % 3 == 0);
            tick();
            chk("stall_valid", out_valid, 1);
        end
        start     = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("stall_release_valid", out_valid, 0);
        chk("stall_no_second_window", busy, 0);

        // 4. Back-to-back: restart on the first valid cycle, then 1 one/cycle -> 16
        run_window(1'b0, 1'b0, 4'hF, 1'b0, 1'b0);
        run_window(1'b0, 1'b0, 4'b0001, 1'b1, 1'b0);

        // 5. Async reset at window cycle 7 discards the partial window
        wait_idle();
        start  = 1'b1;
        bit_in = 4'hF;
        tick();
        start = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        reset_n = 1'b0;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_data", out_data, 0);
        tick();
        reset_n = 1'b1;
        tick();
        run_window(1'b0, 1'b0, 4'hF, 1'b0, 1'b0);

        // 6. Random windows with random ready stalls
        rand_ready = 1'b1;
        for (int w = 0; w < 50; w++) begin
            run_window(1'($urandom_range(0, 1)), 1'b1, 4'h0, 1'b0, 1'b0);
        end
        wait_idle();
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        tick();
        tick();
        chk("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
